// File: rtl/fmul_wb.sv
// Writeback stage for the fractional multiplier: writes a 16-bit product to R0 then R1
// through a shared register-file write port, then publishes the SREG C/Z flags.
module fmul_wb #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_r1,
    input  logic [DATA_W-1:0] i_r0,
    input  logic              i_c,
    input  logic              i_wr_stall,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_flag_we,
    output logic              o_c,
    output logic              o_z,
    output logic              o_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t            state_r;
    logic [DATA_W-1:0] r1_r;
    logic [DATA_W-1:0] r0_r;
    logic              c_r;
    logic              z_r;
    logic              ready_s;
    logic              accept_s;

    function automatic logic is_zero(input logic [2*DATA_W-1:0] value);
        return (value == {(2*DATA_W){1'b0}});
    endfunction

    // Ready goes high in WR_HI on the committing cycle so the next product lands with no bubble.
    assign ready_s  = i_rst_n & ((state_r == IDLE) | ((state_r == WR_HI) & ~i_wr_stall));
    assign accept_s = i_valid & ready_s;
    assign o_ready  = ready_s;

    // Write sequencer plus product holding registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
            r1_r    <= {DATA_W{1'b0}};
            r0_r    <= {DATA_W{1'b0}};
            c_r     <= 1'b0;
            z_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                r1_r <= i_r1;
                r0_r <= i_r0;
                c_r  <= i_c;
                z_r  <= is_zero({i_r1, i_r0});
            end
            case (state_r)
                IDLE: begin
                    if (accept_s) state_r <= WR_LO;
                end
                WR_LO: begin
                    if (!i_wr_stall) state_r <= WR_HI;
                end
                WR_HI: begin
                    if (!i_wr_stall) state_r <= accept_s ? WR_LO : IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Write-port and flag outputs decoded from the sequencer state; strobes qualify on the commit.
    always_comb begin
        o_we      = 1'b0;
        o_waddr   = {ADDR_W{1'b0}};
        o_wdata   = {DATA_W{1'b0}};
        o_flag_we = 1'b0;
        o_c       = 1'b0;
        o_z       = 1'b0;
        o_done    = 1'b0;
        case (state_r)
            IDLE: begin
                o_we = 1'b0;
            end
            WR_LO: begin
                o_we    = 1'b1;
                o_waddr = {ADDR_W{1'b0}};
                o_wdata = r0_r;
            end
            WR_HI: begin
                o_we    = 1'b1;
                o_waddr = {{(ADDR_W-1){1'b0}}, 1'b1};
                o_wdata = r1_r;
                o_c     = c_r;
                o_z     = z_r;
                if (!i_wr_stall) begin
                    o_flag_we = 1'b1;
                    o_done    = 1'b1;
                end else begin
                    o_flag_we = 1'b0;
                    o_done    = 1'b0;
                end
            end
            default: begin
                o_we = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fmul_wb.sv
// Bench for fmul_wb: a queue-of-pending-writes reference model predicts every output each cycle.
module tb_fmul_wb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid;
    logic       ready;
    logic [7:0] r1;
    logic [7:0] r0;
    logic       c;
    logic       stall;
    logic       we;
    logic [4:0] waddr;
    logic [7:0] wdata;
    logic       flag_we;
    logic       oc;
    logic       oz;
    logic       done;

    int total = 0;
    int bad   = 0;

    fmul_wb #(.DATA_W(8), .ADDR_W(5)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready),
        .i_r1(r1), .i_r0(r0), .i_c(c), .i_wr_stall(stall),
        .o_we(we), .o_waddr(waddr), .o_wdata(wdata), .o_flag_we(flag_we),
        .o_c(oc), .o_z(oz), .o_done(done)
    );

    always #5 clk = ~clk;

    // Each accepted product becomes two pending writes; the front of the queue is on the port.
    typedef struct packed {
        logic       hi;
        logic [7:0] d;
        logic       c;
        logic       z;
    } wr_t;
    wr_t  q[$];
    logic acc_last;

    function automatic logic [18:0] model_vec();
        logic rdy, mwe, fwe, mc, mz;
        logic [4:0] a;
        logic [7:0] d;
        rdy = rst_n && (q.size() == 0 || (q.size() == 1 && !stall));
        mwe = 1'b0; a = 5'd0; d = 8'd0; fwe = 1'b0; mc = 1'b0; mz = 1'b0;
        if (q.size() > 0) begin
            mwe = 1'b1;
            d   = q[0].d;
            a   = q[0].hi ? 5'd1 : 5'd0;
            if (q[0].hi) begin
                mc  = q[0].c;
                mz  = q[0].z;
                fwe = !stall;
            end
        end
        return {rdy, mwe, a, d, fwe, mc, mz, fwe};
    endfunction

    function automatic logic [18:0] dut_vec();
        return {ready, we, waddr, wdata, flag_we, oc, oz, done};
    endfunction

    task automatic model_tick();
        logic rdy;
        rdy = rst_n && (q.size() == 0 || (q.size() == 1 && !stall));
        acc_last = 1'b0;
        if (!rst_n) begin
            q.delete();
        end else begin
            if (q.size() > 0 && !stall) void'(q.pop_front());
            if (valid && rdy) begin
                acc_last = 1'b1;
                q.push_back('{1'b0, r0, 1'b0, 1'b0});
                q.push_back('{1'b1, r1, c, ((int'(r1) * 256 + int'(r0)) == 0)});
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b0; r1 = 8'd0; r0 = 8'd0; c = 1'b0; stall = 1'b0;
        q.delete();
        #1;
        total++;
        if (dut_vec() !== 19'd0) begin
            bad++; $display("FAIL reset_outputs got=%h want=%h", dut_vec(), 19'd0);
        end
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (dut_vec() !== model_vec() || ready !== 1'b1) begin
            bad++; $display("FAIL reset_release got=%h want=%h", dut_vec(), model_vec());
        end
        advance();
    endtask

    task automatic test_single();
        valid = 1'b1; r1 = 8'h80; r0 = 8'h00; c = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL single c%0d got=%h want=%h", k, dut_vec(), model_vec());
            end
            if (k == 2) begin
                total++;
                if ({we, waddr, wdata, flag_we, oc, oz, done} !== {1'b1, 5'd1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1}) begin
                    bad++; $display("FAIL single_r1 got we=%b a=%0d d=%h fwe=%b c=%b z=%b done=%b",
                                    we, waddr, wdata, flag_we, oc, oz, done);
                end
            end
            advance();
            valid = 1'b0;
        end
    endtask

    task automatic test_zero(input logic [7:0] h, input logic [7:0] l, input logic cin, input logic zexp);
        valid = 1'b1; r1 = h; r0 = l; c = cin;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL zero c%0d got=%h want=%h", k, dut_vec(), model_vec());
            end
            if (k == 2) begin
                total++;
                if (oz !== zexp || oc !== cin || flag_we !== 1'b1) begin
                    bad++; $display("FAIL zero_flags got z=%b c=%b want z=%b c=%b", oz, oc, zexp, cin);
                end
            end
            advance();
            valid = 1'b0;
        end
    endtask

    task automatic test_stall();
        int dones;
        dones = 0;
        valid = 1'b1; r1 = 8'h5A; r0 = 8'hA5; c = 1'b1;
        for (int k = 0; k < 8; k++) begin
            stall = (k >= 1 && k <= 3);
            @(negedge clk);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL stall c%0d got=%h want=%h", k, dut_vec(), model_vec());
            end
            if (done === 1'b1) dones++;
            advance();
            valid = 1'b0;
        end
        stall = 1'b0;
        total++;
        if (dones !== 1) begin
            bad++; $display("FAIL stall_done_count got=%0d want=1", dones);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] log_d[$];
        int first, last, nacc;
        first = -1; last = -1; nacc = 0;
        valid = 1'b1; r1 = 8'h12; r0 = 8'h34; c = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL b2b c%0d got=%h want=%h", k, dut_vec(), model_vec());
            end
            if (we === 1'b1 && stall === 1'b0) begin
                log_d.push_back(wdata);
                if (first < 0) first = k;
                last = k;
            end
            advance();
            if (acc_last) begin
                nacc++;
                if (nacc == 1) begin r1 = 8'hFF; r0 = 8'hFE; c = 1'b1; end
                else valid = 1'b0;
            end
        end
        total++;
        if (log_d.size() != 4 || last - first != 3 || log_d[0] !== 8'h34 || log_d[1] !== 8'h12
            || log_d[2] !== 8'hFE || log_d[3] !== 8'hFF) begin
            bad++; $display("FAIL b2b_sequence got n=%0d span=%0d want 34 12 FE FF over 4 cycles",
                            log_d.size(), last - first + 1);
        end
    endtask

    task automatic test_wrhi_stall();
        valid = 1'b1; r1 = 8'h33; r0 = 8'h44; c = 1'b1;
        for (int k = 0; k < 8; k++) begin
            stall = (k == 2 || k == 3);
            @(negedge clk);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL wrhi_stall c%0d got=%h want=%h", k, dut_vec(), model_vec());
            end
            if (stall) begin
                total++;
                if (ready !== 1'b0 || wdata !== 8'h33 || oc !== 1'b1 || oz !== 1'b0) begin
                    bad++; $display("FAIL wrhi_hold got rdy=%b d=%h c=%b z=%b want 0 33 1 0", ready, wdata, oc, oz);
                end
            end
            advance();
            if (acc_last) begin
                if (r1 == 8'h33) begin r1 = 8'h00; r0 = 8'h00; c = 1'b0; end
                else valid = 1'b0;
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_reset_mid();
        valid = 1'b1; r1 = 8'h9C; r0 = 8'h1D; c = 1'b1;
        advance();
        valid = 1'b0;
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        total++;
        if (we !== 1'b0 || ready !== 1'b0 || done !== 1'b0 || dut_vec() !== model_vec()) begin
            bad++; $display("FAIL reset_mid got=%h want=%h", dut_vec(), model_vec());
        end
        advance();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL reset_mid_after c%0d got=%h want=%h", k, dut_vec(), model_vec());
            end
            advance();
        end
    endtask

    task automatic test_random();
        valid = 1'b0;
        for (int k = 0; k < 400; k++) begin
            stall = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL random c%0d got=%h want=%h", k, dut_vec(), model_vec());
            end
            advance();
            if (acc_last || !valid) begin
                valid = ($urandom_range(0, 2) != 0);
                r1 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                r0 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                c  = 1'($urandom);
            end
        end
        stall = 1'b0;
        valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero(8'h00, 8'h00, 1'b1, 1'b1);
        test_zero(8'h00, 8'h02, 1'b0, 1'b0);
        test_stall();
        test_back_to_back();
        test_wrhi_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
